regfile_stream_ctrl: RTL and testbench
======================================

REGFILE_STREAM_CTRL -- requirements
Module: regfile_stream_ctrl

Interface
REQ-001 Parameter n, default 32: data word width in bits.
REQ-002 Parameter m, default 32: register file depth; power of two; AW = $clog2(m).
REQ-003 clk  in  1  single clock; all logic updates on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cmd_valid, cmd_ready  in/out  1/1  command handshake; a command is accepted on a cycle where both are 1.
REQ-006 cmd_op  in  1  command type: 0 = LOAD (stream into file), 1 = DUMP (file out to stream).
REQ-007 cmd_base, cmd_len  in  AW/AW  start address; word count minus one (1..m words).
REQ-008 s_data, s_valid, s_ready  in/in/out  n/1/1  LOAD input stream.
REQ-009 m_data, m_valid, m_ready, m_last  out/out/in/out  n/1/1/1  DUMP output stream; m_last marks the final word.
REQ-010 rf_we, rf_rw, rf_wdata  out  1/AW/n  register file write port.
REQ-011 rf_r1  out  AW  register file read address; rf_q1 (in, n) returns its data one cycle later.
REQ-012 busy  out  1  high while a command is in progress; done  out  1  one-cycle completion pulse.
REQ-013 csum  out  n  XOR checksum of the last completed command (see Configuration).

Function
REQ-014 The block SHALL implement the states IDLE, LOAD, DUMP and FIN.
REQ-015 cmd_ready SHALL be 1 only in IDLE.
REQ-016 On command acceptance, the block SHALL latch base, len and op, clear its offset counter, and enter LOAD or DUMP on the next cycle.
REQ-017 The address for word k SHALL be (base + k) mod m; wrap-around past m-1 to 0 is legal.
REQ-018 In LOAD, s_ready SHALL be 1.
- Each s_valid&s_ready beat SHALL assert rf_we in the same cycle, with rf_rw = current address and rf_wdata = s_data.
- Throughput: 1 word/cycle.
REQ-019 rf_we SHALL be 0 in every state except LOAD, and SHALL be 0 during LOAD cycles without a beat.
REQ-020 In DUMP, the block SHALL issue reads on rf_r1 and capture rf_q1 one cycle later into a 2-entry output FIFO.
- A read SHALL be issued only if FIFO occupancy plus in-flight reads is below 2.
- Sustained throughput: 1 word/cycle while m_ready = 1.
REQ-021 m_data/m_valid SHALL present the FIFO head; words SHALL leave in address order; no word is dropped or duplicated under any m_ready pattern.
REQ-022 m_last SHALL be 1 exactly with word len.
REQ-023 After the final LOAD beat, or the final DUMP handshake, the block SHALL enter FIN.
- In FIN, done is 1 for one cycle, then the block returns to IDLE.
REQ-024 busy SHALL equal (state != IDLE).
REQ-025 s_ready SHALL be 0 outside LOAD; m_valid SHALL be 0 outside DUMP.
REQ-026 cmd_valid while busy SHALL be ignored and not queued.

Reset
REQ-027 reset SHALL force IDLE, empty the FIFO, cancel in-flight reads and clear the counters, even mid-command.
REQ-028 Reset values: cmd_ready 1; s_ready, m_valid, m_last, rf_we, busy, done 0; rf_rw, rf_r1, rf_wdata, m_data, csum 0.
REQ-029 Register file contents SHALL NOT be touched by reset.
- Words already written by an aborted LOAD remain in the file.

Configuration
REQ-030 With macro RFSC_CHECKSUM_EN defined:
- csum SHALL accumulate the XOR of every word written (LOAD) or delivered (DUMP) during a command, cleared at acceptance.
- csum SHALL be stable from the done pulse until the next acceptance.
REQ-031 Without RFSC_CHECKSUM_EN, csum SHALL be constant 0 and no accumulator logic SHALL exist.

Verification
REQ-032 LOAD base=0, len=3, data 0x11,0x22,0x33,0x44 with s_valid always 1 -> four consecutive rf_we pulses at addresses 0..3; done 1 cycle after the last beat.
REQ-033 DUMP base=30, len=3 after loading addr i = i*0x100 -> m_data 0x1E00,0x1F00,0x0000,0x0100 (wrap 31->0); m_last on 0x0100.
REQ-034 DUMP len=7 with m_ready toggling 1,0,0,1 repeating -> all 8 words in order, none lost or duplicated; rf_r1 never runs more than 2 ahead of delivery.
REQ-035 reset asserted mid-DUMP (after 2 words) -> next cycle busy=0, m_valid=0, cmd_ready=1; a new DUMP then returns correct data from base.
REQ-036 cmd_valid held 1 during a LOAD -> no second acceptance until cmd_ready returns; LOAD len=31 with s_valid gaps writes all 32 addresses.
REQ-037 RFSC_CHECKSUM_EN defined, LOAD 0x0F,0xF0,0xFF -> csum=0x00 at done; with the macro undefined, csum stays 0.

Source files
------------

// File: rtl/regfile_stream_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_stream_ctrl
//
// Moves blocks of words between a streaming interface and an external
// register file that has one write port and one read port. The read port
// returns data one cycle after the address is presented.
//   LOAD (cmd_op=0): s_* stream words are written to base..base+len (mod m).
//   DUMP (cmd_op=1): words at base..base+len (mod m) are read and sent out
//                    on m_*. A 2-entry FIFO absorbs m_ready back-pressure.
//
// Ports
//   clk, reset                 : single clock, synchronous active-high reset
//   cmd_valid/cmd_ready        : command handshake (ready only when idle)
//   cmd_op, cmd_base, cmd_len  : op, start address, word count minus one
//   s_data/s_valid/s_ready     : LOAD input stream
//   m_data/m_valid/m_ready/m_last : DUMP output stream, m_last on final word
//   rf_we/rf_rw/rf_wdata       : register file write port
//   rf_r1/rf_q1                : register file read address / data (+1 cycle)
//   busy, done                 : command in progress / one-cycle completion
//   csum                       : XOR checksum of the last command
//
// Build option: define RFSC_CHECKSUM_EN to include the checksum accumulator.
// Without it csum is tied to zero.
// ---------------------------------------------------------------------------
module regfile_stream_ctrl #(
  parameter int n = 32,
  parameter int m = 32,
  localparam int AW = $clog2(m)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_op,
  input  logic [AW-1:0] cmd_base,
  input  logic [AW-1:0] cmd_len,
  input  logic [n-1:0]  s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic [n-1:0]  m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          rf_we,
  output logic [AW-1:0] rf_rw,
  output logic [n-1:0]  rf_wdata,
  output logic [AW-1:0] rf_r1,
  input  logic [n-1:0]  rf_q1,
  output logic          busy,
  output logic          done,
  output logic [n-1:0]  csum
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DUMP, ST_FIN} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] wr_off_q, wr_off_d;   // LOAD beats accepted so far
  logic [AW:0]   rd_off_q, rd_off_d;   // DUMP reads issued (reaches len+1)
  logic [AW-1:0] dl_off_q, dl_off_d;   // DUMP words delivered so far
  logic          inflight_q, inflight_d;
  logic [n-1:0]  fifo_mem_q [2];
  logic [n-1:0]  fifo_mem_d [2];
  logic          fifo_wp_q, fifo_wp_d;
  logic          fifo_rp_q, fifo_rp_d;
  logic [1:0]    fifo_cnt_q, fifo_cnt_d;

  logic       in_load, in_dump, accept, beat, pop, push, rd_issue;
  logic [2:0] occ_after;

  assign in_load = (state_q == ST_LOAD);
  assign in_dump = (state_q == ST_DUMP);
  assign accept  = (state_q == ST_IDLE) && cmd_valid;
  assign beat    = in_load && s_valid;
  assign pop     = m_valid && m_ready;
  // Only reads issued during DUMP are ever in flight, so every return is a push.
  assign push    = inflight_q;

  // Occupancy counts the word leaving this cycle, so a read can be issued in
  // the same cycle as a pop; this keeps 1 word/cycle with only two entries.
  assign occ_after = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
  assign rd_issue  = in_dump && (rd_off_q <= {1'b0, len_q}) && (occ_after < 3'd2);

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FIN);
  assign s_ready   = in_load;
  assign rf_we     = beat;
  assign rf_rw     = base_q + wr_off_q;
  assign rf_wdata  = in_load ? s_data : '0;
  assign rf_r1     = base_q + rd_off_q[AW-1:0];
  assign m_valid   = in_dump && (fifo_cnt_q != 2'd0);
  assign m_data    = m_valid ? fifo_mem_q[fifo_rp_q] : '0;
  assign m_last    = m_valid && (dl_off_q == len_q);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    wr_off_d   = wr_off_q;
    rd_off_d   = rd_off_q;
    dl_off_d   = dl_off_q;
    inflight_d = rd_issue;
    fifo_mem_d = fifo_mem_q;
    fifo_wp_d  = fifo_wp_q;
    fifo_rp_d  = fifo_rp_q;
    fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

    if (push) begin
      fifo_mem_d[fifo_wp_q] = rf_q1;
      fifo_wp_d             = ~fifo_wp_q;
    end
    if (pop) fifo_rp_d = ~fifo_rp_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          // The op is carried by the state itself from here on.
          base_d     = cmd_base;
          len_d      = cmd_len;
          wr_off_d   = '0;
          rd_off_d   = '0;
          dl_off_d   = '0;
          fifo_wp_d  = 1'b0;
          fifo_rp_d  = 1'b0;
          fifo_cnt_d = 2'd0;
          state_d    = cmd_op ? ST_DUMP : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (beat) begin
          wr_off_d = wr_off_q + AW'(1);
          if (wr_off_q == len_q) state_d = ST_FIN;
        end
      end
      ST_DUMP: begin
        if (rd_issue) rd_off_d = rd_off_q + (AW+1)'(1);
        if (pop) begin
          dl_off_d = dl_off_q + AW'(1);
          if (dl_off_q == len_q) state_d = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      wr_off_q   <= '0;
      rd_off_q   <= '0;
      dl_off_q   <= '0;
      inflight_q <= 1'b0;
      fifo_wp_q  <= 1'b0;
      fifo_rp_q  <= 1'b0;
      fifo_cnt_q <= 2'd0;
      for (int i = 0; i < 2; i++) fifo_mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      wr_off_q   <= wr_off_d;
      rd_off_q   <= rd_off_d;
      dl_off_q   <= dl_off_d;
      inflight_q <= inflight_d;
      fifo_wp_q  <= fifo_wp_d;
      fifo_rp_q  <= fifo_rp_d;
      fifo_cnt_q <= fifo_cnt_d;
      for (int i = 0; i < 2; i++) fifo_mem_q[i] <= fifo_mem_d[i];
    end
  end

`ifdef RFSC_CHECKSUM_EN
  logic [n-1:0] csum_q, csum_d;

  // Cleared at acceptance; holds its value from done until the next command.
  always_comb begin
    csum_d = csum_q;
    if (accept)    csum_d = '0;
    else if (beat) csum_d = csum_q ^ s_data;
    else if (pop)  csum_d = csum_q ^ m_data;
  end

  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_regfile_stream_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for regfile_stream_ctrl. An external register file model (registered
// read) is attached to the DUT; a separate golden array records what the bench
// intends each address to hold, and every write and every delivered word is
// checked against it.
// ---------------------------------------------------------------------------
module tb_regfile_stream_ctrl;
  localparam int N  = 32;
  localparam int M  = 32;
  localparam int AW = $clog2(M);
`ifdef RFSC_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_op;
  logic [AW-1:0] cmd_base, cmd_len;
  logic [N-1:0]  s_data;
  logic          s_valid, s_ready;
  logic [N-1:0]  m_data;
  logic          m_valid, m_ready, m_last;
  logic          rf_we;
  logic [AW-1:0] rf_rw, rf_r1;
  logic [N-1:0]  rf_wdata, rf_q1;
  logic          busy, done;
  logic [N-1:0]  csum;

  regfile_stream_ctrl #(.n(N), .m(M)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .rf_we(rf_we), .rf_rw(rf_rw), .rf_wdata(rf_wdata),
    .rf_r1(rf_r1), .rf_q1(rf_q1),
    .busy(busy), .done(done), .csum(csum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External register file: write port plus one-cycle registered read.
  logic [N-1:0] ram [M];
  always @(posedge clk) begin
    if (rf_we) ram[rf_rw] <= rf_wdata;
    rf_q1 <= ram[rf_r1];
  end

  logic [N-1:0] gold [M];       // intended contents of each address
  logic [N-1:0] load_q [$];     // optional fixed data for the next LOAD
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1; cmd_valid = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rf_rw", rf_rw, 0);
    chk("rst_rf_r1", rf_r1, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_csum", csum, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    $display("[%0t] reset", $time);
  endtask

  task automatic do_load(input int base, input int len, input int gap_pct, input bit hold_cmd);
    int k, cyc;
    bit sv;
    logic [N-1:0] d, x;
    x = '0; k = 0; cyc = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_base = AW'(base); cmd_len = AW'(len);
    @(negedge clk);
    chk("ld_cmd_ready", cmd_ready, 1);
    while (k <= len && cyc < 40 * (len + 1) + 50) begin
      @(posedge clk); #1;
      if (hold_cmd) begin
        cmd_op = 1'($urandom); cmd_base = AW'($urandom); cmd_len = AW'($urandom);
      end else begin
        cmd_valid = 1'b0;
      end
      sv = ($urandom_range(99) >= gap_pct);
      d = $urandom;
      if (sv && load_q.size() > 0) d = load_q.pop_front();
      s_valid = sv; s_data = d;
      @(negedge clk);
      chk("ld_busy", busy, 1);
      chk("ld_cmd_ready_busy", cmd_ready, 0);
      chk("ld_s_ready", s_ready, 1);
      chk("ld_m_valid", m_valid, 0);
      chk("ld_rf_we", rf_we, sv);
      if (sv) begin
        chk("ld_rf_rw", rf_rw, (base + k) % M);
        chk("ld_rf_wdata", rf_wdata, d);
        gold[(base + k) % M] = d;
        x ^= d;
        k++;
      end
      cyc++;
    end
    if (k <= len) begin
      chk("ld_timeout", 0, 1);
      do_reset();
      return;
    end
    @(posedge clk); #1;
    s_valid = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("ld_done", done, 1);
    chk("ld_fin_s_ready", s_ready, 0);
    chk("ld_fin_rf_we", rf_we, 0);
    chk("ld_fin_busy", busy, 1);
    chk("ld_csum", csum, CSUM_ON ? x : '0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("ld_idle_done", done, 0);
    chk("ld_idle_busy", busy, 0);
    chk("ld_idle_cmd_ready", cmd_ready, 1);
    chk("ld_csum_hold", csum, CSUM_ON ? x : '0);
    $display("[%0t] load base=%0d len=%0d cycles=%0d csum=%h", $time, base, len, cyc, x);
  endtask

  // mode: 0 = m_ready always 1, 1 = pattern 1,0,0,1, 2 = random.
  // abort_at >= 0 asserts reset after that many words were delivered.
  task automatic do_dump(input int base, input int len, input int mode, input int abort_at);
    int k, cyc, ph, ahead;
    bit mr;
    logic [N-1:0] x;
    x = '0; k = 0; cyc = 0; ph = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 1'b1; cmd_base = AW'(base); cmd_len = AW'(len); m_ready = 1'b0;
    @(negedge clk);
    chk("dp_cmd_ready", cmd_ready, 1);
    while (k <= len && cyc < 10 * (len + 1) + 20) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      case (mode)
        0:       mr = 1'b1;
        1:       mr = ((ph % 4) == 0) || ((ph % 4) == 3);
        default: mr = 1'($urandom);
      endcase
      ph++;
      m_ready = mr;
      @(negedge clk);
      chk("dp_busy", busy, 1);
      chk("dp_s_ready", s_ready, 0);
      chk("dp_rf_we", rf_we, 0);
      // addresses requested but not yet delivered, from the read address
      ahead = (int'(rf_r1) - base - k + 2 * M) % M;
      chk("dp_ahead_le2", (ahead <= 2), 1);
      if (m_valid) chk("dp_m_last", m_last, (k == len));
      cyc++;
      if (m_valid && mr) begin
        chk("dp_m_data", m_data, gold[(base + k) % M]);
        x ^= m_data;
        k++;
        if (abort_at >= 0 && k == abort_at) break;
      end
    end
    if (abort_at >= 0 && k == abort_at) begin
      @(posedge clk); #1;
      reset = 1'b1; m_ready = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("ab_busy", busy, 0);
      chk("ab_m_valid", m_valid, 0);
      chk("ab_cmd_ready", cmd_ready, 1);
      chk("ab_csum", csum, 0);
      $display("[%0t] dump base=%0d len=%0d aborted after %0d words", $time, base, len, k);
      return;
    end
    if (k <= len) begin
      chk("dp_timeout", 0, 1);
      do_reset();
      return;
    end
    if (mode == 0) chk("dp_thruput", (cyc <= len + 5), 1);
    @(posedge clk); #1;
    m_ready = 1'($urandom);
    @(negedge clk);
    chk("dp_done", done, 1);
    chk("dp_fin_m_valid", m_valid, 0);
    chk("dp_fin_busy", busy, 1);
    chk("dp_csum", csum, CSUM_ON ? x : '0);
    @(posedge clk); #1;
    m_ready = 1'b0;
    @(negedge clk);
    chk("dp_idle_done", done, 0);
    chk("dp_idle_busy", busy, 0);
    chk("dp_csum_hold", csum, CSUM_ON ? x : '0);
    $display("[%0t] dump base=%0d len=%0d mode=%0d cycles=%0d csum=%h", $time, base, len, mode, cyc, x);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, l;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_len = '0;
    s_data = '0; s_valid = 1'b0; m_ready = 1'b0;
    do_reset();

    // four back-to-back beats at addresses 0..3
    load_q = {32'h11, 32'h22, 32'h33, 32'h44};
    do_load(0, 3, 0, 1'b0);

    // fill the whole file with addr*0x100
    for (int i = 0; i < M; i++) load_q.push_back(N'(i * 32'h100));
    do_load(0, M - 1, 0, 1'b0);

    do_dump(30, 3, 0, -1);          // wraps 31 -> 0
    do_dump(0, 7, 1, -1);           // back-pressure pattern
    do_dump(4, 9, 2, 2);            // reset after two words
    do_dump(4, 9, 0, -1);           // restart from base
    do_load(7, M - 1, 35, 1'b1);    // gaps, cmd_valid held throughout
    do_dump(7, M - 1, 2, -1);

    load_q = {32'h0F, 32'hF0, 32'hFF};
    do_load(5, 2, 0, 1'b0);
    do_dump(5, 2, 0, -1);

    for (int t = 0; t < 24; t++) begin
      b = int'($urandom_range(M - 1));
      l = ($urandom_range(3) == 0) ? int'($urandom_range(M - 1)) : int'($urandom_range(7));
      if ($urandom_range(1) == 1) do_dump(b, l, int'($urandom_range(2)), -1);
      else                        do_load(b, l, int'($urandom_range(50)), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
